// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side signals.
// Handshake rule for every valid/ready pair below: a transfer happens on a
// rising edge where both valid and ready are 1; the source keeps its payload
// stable while valid is high and unaccepted, except that the fetch unit may
// withdraw imem_req_valid in a redirect or reset cycle. The response channel
// has no ready: the fetch unit always absorbs imem_rsp_valid.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, instr_ready
  );

  // Memory / execute / decode side.
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: issues word-aligned requests, tags responses
// with their PC, buffers them in a prefetch FIFO and discards responses made
// stale by a redirect.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [XLEN-1:0] tag_q [DEPTH];
  logic [XLEN-1:0] tag_d [DEPTH];
  logic [XLEN-1:0] fifo_pc_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_d [DEPTH];
  logic [31:0]     fifo_instr_q [DEPTH];
  logic [31:0]     fifo_instr_d [DEPTH];

  logic [CW-1:0]   live;
  logic            credit;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_take;
  logic            push;
  logic            instr_valid;
  logic            pop;

  // Handshake qualification and credit check.
  always_comb begin
    live = inflight_q - drop_q;
    // Besides the FIFO credit, in-flight requests (live plus those still to
    // be dropped) are capped at DEPTH so chained redirects cannot overflow
    // the counters or the PC tag queue.
    credit = (({1'b0, count_q} + {1'b0, live}) < (CW+1)'(DEPTH)) &&
             (inflight_q < CW'(DEPTH));
    req_valid   = reset && credit && !bus.redirect_valid;
    req_fire    = req_valid && bus.imem_req_ready;
    // A response with nothing outstanding is a protocol error and ignored.
    rsp_take    = bus.imem_rsp_valid && (inflight_q != '0);
    push        = rsp_take && (drop_q == '0) && !bus.redirect_valid;
    instr_valid = reset && (count_q != '0) && !bus.redirect_valid;
    pop         = instr_valid && bus.instr_ready;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = instr_valid;
  assign bus.instr          = fifo_instr_q[rd_ptr_q];
  assign bus.instr_pc       = fifo_pc_q[rd_ptr_q];

  // Next-state for PC, counters and pointers; a redirect overrides FIFO
  // and drop bookkeeping for the cycle.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_take);
    tag_wr_d   = tag_wr_q + AW'(req_fire);
    tag_rd_d   = tag_rd_q + AW'(rsp_take);
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
      // Everything still outstanding after this cycle's response is stale.
      drop_d     = inflight_q - CW'(rsp_take);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (rsp_take && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage updates: PC tag written on request, FIFO entry written on push.
  always_comb begin
    tag_d        = tag_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    if (req_fire) begin
      tag_d[tag_wr_q] = fetch_pc_q;
    end
    if (push) begin
      fifo_pc_d[wr_ptr_q]    = tag_q[tag_rd_q];
      fifo_instr_d[wr_ptr_q] = bus.imem_rsp_data;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // Data storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    tag_q        <= tag_d;
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with configurable latency,
// epoch-tagged expected-instruction queue, vector table plus corner sequences.
module tb_fetch_unit;
  localparam int          XLEN    = 32;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mem_t;

  typedef struct {
    bit          ir;
    bit          e_rv;
    logic [31:0] e_ra;
    bit          e_iv;
    logic [31:0] e_ipc;
  } vec_t;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus ();
  fetch_unit_if #(.XLEN(XLEN)) wbus ();

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .reset(reset), .bus(wbus)
  );

  // Scoreboard and model state
  logic [63:0] exp_q [$];
  mem_t        mem_q [$];
  logic [31:0] w_addrs [$];
  logic [31:0] exp_req_addr;
  int          cyc, lat, epoch, delivered, n_acc;
  int          n_pass, n_total;
  logic [31:0] last_del_pc;
  bit          hold_prev;
  logic [31:0] hold_pc, hold_instr;
  logic        obs_rv, obs_iv;
  logic [31:0] obs_ra, obs_ipc, obs_instr;
  vec_t        vec [12];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    n_total++;
    $display("FAIL %s: got %h expected none (cycle %0d)", name, act, cyc);
  endtask

  // Driver: one clock cycle of stimulus, memory response and observation.
  task automatic step(input bit rst, input bit rr, input bit ir, input bit rd,
                      input logic [31:0] rpc);
    mem_t        m;
    logic [63:0] e;
    @(negedge clk);
    reset = rst;
    bus.imem_req_ready = rr;
    bus.instr_ready    = ir;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (!rst) begin
      mem_q.delete();
      exp_q.delete();
      w_addrs.delete();
      epoch++;
      exp_req_addr = 32'h0;
    end else begin
      if (rd) begin
        epoch++;
        exp_q.delete();
        exp_req_addr = rpc & 32'hFFFF_FFFC;
      end
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        m = mem_q.pop_front();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_data(m.addr);
        if (m.ep == epoch) exp_q.push_back({m.addr, mem_data(m.addr)});
      end
    end
    #1;
    obs_rv    = bus.imem_req_valid;
    obs_ra    = bus.imem_req_addr;
    obs_iv    = bus.instr_valid;
    obs_ipc   = bus.instr_pc;
    obs_instr = bus.instr;
    if (!rst || rd) begin
      chk("gated_req_valid", 64'(obs_rv), 64'd0);
      chk("gated_instr_valid", 64'(obs_iv), 64'd0);
    end
    if (rst && !rd && hold_prev) begin
      chk("hold_valid", 64'(obs_iv), 64'd1);
      chk("hold_data", {obs_ipc, obs_instr}, {hold_pc, hold_instr});
    end
    hold_prev  = rst && !rd && obs_iv && !ir;
    hold_pc    = obs_ipc;
    hold_instr = obs_instr;
    if (obs_rv && rr) begin
      n_acc++;
      chk("req_addr", 64'(obs_ra), 64'(exp_req_addr));
      m.addr = obs_ra;
      m.due  = cyc + lat;
      m.ep   = epoch;
      mem_q.push_back(m);
      exp_req_addr = exp_req_addr + 32'd4;
    end
    if (obs_iv && ir) begin
      delivered++;
      last_del_pc = obs_ipc;
      if (exp_q.size() == 0) fail("unexpected_instr", {obs_ipc, obs_instr});
      else begin
        e = exp_q.pop_front();
        chk("instr_stream", {obs_ipc, obs_instr}, e);
      end
    end
    if (rst && wbus.imem_req_valid && w_addrs.size() < 8) w_addrs.push_back(wbus.imem_req_addr);
    cyc++;
  endtask

  // Waits (bounded) for the next delivered instruction and checks its PC.
  task automatic expect_first(input string name, input logic [31:0] pc);
    int d0;
    d0 = delivered;
    for (int i = 0; i < 20 && delivered == d0; i++) step(1, 1, 1, 0, 32'h0);
    if (delivered == d0) fail({name, "_timeout"}, 64'(d0));
    else chk(name, 64'(last_del_pc), 64'(pc));
  endtask

  initial begin
    bit rr_r, ir_r;
    int d0;
    n_pass = 0; n_total = 0; cyc = 0; lat = 1; epoch = 0; delivered = 0; n_acc = 0;
    hold_prev = 0; exp_req_addr = 32'h0;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.instr_ready = 0;
    wbus.imem_req_ready = 1; wbus.imem_rsp_valid = 0; wbus.imem_rsp_data = '0;
    wbus.redirect_valid = 0; wbus.redirect_pc = '0; wbus.instr_ready = 0;

    // Streaming then backpressure, 1-cycle memory, from reset release.
    vec[0]  = '{1, 1, 32'h00, 0, 32'h00};
    vec[1]  = '{1, 1, 32'h04, 0, 32'h00};
    vec[2]  = '{1, 1, 32'h08, 1, 32'h00};
    vec[3]  = '{0, 1, 32'h0C, 1, 32'h04};
    vec[4]  = '{0, 1, 32'h10, 1, 32'h04};
    vec[5]  = '{0, 0, 32'h00, 1, 32'h04};
    vec[6]  = '{0, 0, 32'h00, 1, 32'h04};
    vec[7]  = '{1, 0, 32'h00, 1, 32'h04};
    vec[8]  = '{1, 1, 32'h14, 1, 32'h08};
    vec[9]  = '{1, 1, 32'h18, 1, 32'h0C};
    vec[10] = '{1, 1, 32'h1C, 1, 32'h10};
    vec[11] = '{1, 1, 32'h20, 1, 32'h14};

    step(0, 1, 1, 0, 32'h0);
    step(0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      step(1, 1, vec[i].ir, 0, 32'h0);
      chk($sformatf("vec%0d_req_valid", i), 64'(obs_rv), 64'(vec[i].e_rv));
      if (vec[i].e_rv) chk($sformatf("vec%0d_req_addr", i), 64'(obs_ra), 64'(vec[i].e_ra));
      chk($sformatf("vec%0d_instr_valid", i), 64'(obs_iv), 64'(vec[i].e_iv));
      if (vec[i].e_iv) chk($sformatf("vec%0d_instr_pc", i), 64'(obs_ipc), 64'(vec[i].e_ipc));
    end

    // Wrap-around instance: credit stops it after DEPTH requests.
    chk("wrap_count", 64'(w_addrs.size()), 64'd4);
    if (w_addrs.size() == 4) begin
      chk("wrap_addr0", 64'(w_addrs[0]), 64'hFFFF_FFF8);
      chk("wrap_addr1", 64'(w_addrs[1]), 64'hFFFF_FFFC);
      chk("wrap_addr2", 64'(w_addrs[2]), 64'h0000_0000);
      chk("wrap_addr3", 64'(w_addrs[3]), 64'h0000_0004);
    end

    // Mid-stream reset for one cycle.
    step(0, 1, 1, 0, 32'h0);
    step(1, 1, 1, 0, 32'h0);
    chk("rst_restart_valid", 64'(obs_rv), 64'd1);
    chk("rst_restart_addr", 64'(obs_ra), 64'd0);
    chk("rst_fifo_empty", 64'(obs_iv), 64'd0);

    // Backpressure from reset: exactly DEPTH requests, head held.
    step(0, 1, 0, 0, 32'h0);
    n_acc = 0;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 32'h0);
    chk("bp_req_count", 64'(n_acc), 64'(DEPTH));
    chk("bp_req_stalled", 64'(obs_rv), 64'd0);
    chk("bp_head_valid", 64'(obs_iv), 64'd1);
    chk("bp_head_pc", 64'(obs_ipc), 64'h0);
    d0 = n_acc;
    for (int i = 0; i < 10 && n_acc == d0; i++) step(1, 1, 1, 0, 32'h0);
    if (n_acc == d0) fail("bp_resume_timeout", 64'(n_acc));
    else chk("bp_resume_addr", 64'(obs_ra), 64'h10);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 32'h0);

    // Redirect with three requests in flight, 3-cycle memory.
    lat = 3;
    step(0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 1, 32'h103);
    step(1, 1, 1, 0, 32'h0);
    chk("redir_req_valid", 64'(obs_rv), 64'd1);
    chk("redir_req_addr", 64'(obs_ra), 64'h100);
    expect_first("redir_first_pc", 32'h100);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 32'h0);

    // Redirect coinciding with a response and a ready head.
    lat = 1;
    step(0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 32'h0);
    chk("coinc_pre_valid", 64'(obs_iv), 64'd1);
    step(1, 1, 1, 1, 32'h200);
    step(1, 1, 1, 0, 32'h0);
    chk("coinc_req_addr", 64'(obs_ra), 64'h200);
    expect_first("coinc_first_pc", 32'h200);

    // Back-to-back redirects: the last one wins.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 1, 32'h300);
    step(1, 1, 1, 1, 32'h402);
    step(1, 1, 1, 0, 32'h0);
    chk("b2b_req_addr", 64'(obs_ra), 64'h400);
    expect_first("b2b_first_pc", 32'h400);

    // Random request and decode backpressure over 100 instructions.
    lat = 2;
    d0 = delivered;
    for (int i = 0; i < 3000 && delivered < d0 + 100; i++) begin
      rr_r = 1'($urandom_range(0, 1));
      ir_r = ($urandom_range(0, 3) != 0);
      step(1, rr_r, ir_r, 0, 32'h0);
    end
    chk("rand_delivered", 64'(delivered - d0), 64'd100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation RV32I core.
- Replaces the single-cycle PC-to-Instr path with a decoupled fetch unit that has:
  - a valid/ready request channel to instruction memory,
  - an in-order response channel,
  - a DEPTH-entry prefetch FIFO,
  - redirect (branch/jump) handling that flushes stale instructions.
- Feeds the decode stage through a valid/ready instruction channel.

Parameters:
- XLEN, 32, width of PC and memory address.
- DEPTH, 4, prefetch FIFO entries and maximum in-flight plus buffered instructions. Power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch address after reset (XLEN wide, bits [1:0] must be 0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted).
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  word-aligned fetch address.
- imem_rsp_valid  input  1  response valid (in order, no backpressure).
- imem_rsp_data  input  32  fetched instruction word.
- redirect_valid  input  1  PC redirect from execute (taken branch/jump).
- redirect_pc  input  XLEN  redirect target; bits [1:0] ignored (treated as 0).
- instr_valid  output  1  instruction available to decode.
- instr_ready  input  1  decode consumes instruction.
- instr  output  32  instruction word (FIFO head).
- instr_pc  output  XLEN  PC of instr.

Behaviour:
- Reset (sampled reset==0 at rising edge):
  - fetch_pc=RESET_PC; FIFO empty; inflight=0; drop=0.
  - imem_req_valid=0 and instr_valid=0 while reset is low (combinationally gated).
- Counters:
  - inflight = requests accepted but not yet responded.
  - drop = responses still to be discarded.
  - Both counters are clog2(DEPTH)+1 bits wide.
- Credit: live = inflight - drop. A request may issue only when fifo_count + live < DEPTH, so the FIFO can never overflow.
- Request:
  - imem_req_valid = reset && credit && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - Acceptance = imem_req_valid && imem_req_ready. On acceptance: inflight+1, push request PC to the PC tag queue, fetch_pc += 4 (modulo 2^XLEN, wraps to 0).
  - imem_req_valid may drop without acceptance only in a redirect cycle or a reset cycle. Memory must tolerate this.
- Response:
  - Each imem_rsp_valid decrements inflight.
  - If drop>0: drop-1 and the data is discarded.
  - Otherwise: push {tag PC, imem_rsp_data} into the FIFO.
  - A response with inflight==0 is a protocol error and is ignored.
- Output:
  - instr_valid = reset && !fifo_empty && !redirect_valid.
  - instr and instr_pc come from the FIFO head and stay stable until a handshake.
  - Pop on instr_valid && instr_ready.
- Redirect (redirect_valid==1 at edge) takes priority over all other events in that cycle:
  - fetch_pc = {redirect_pc[XLEN-1:2],2'b00}.
  - FIFO flushed; no pop occurs.
  - drop = inflight minus any response arriving in the redirect cycle (that response is discarded too).
  - No request is issued in the redirect cycle.
  - Fetch at the new PC may issue the next cycle.
- Simultaneous push and pop in the same cycle keeps fifo_count unchanged, including when the FIFO is full.
- Latency: with 1-cycle memory and imem_req_ready=1:
  - request at cycle N, response at N+1, instr_valid at N+2.
  - Sustained throughput is 1 instr/cycle when DEPTH ≥ 2 + memory latency.
- Back-to-back redirects: each redirect recomputes drop from current inflight; the last redirect wins.
- Reset asserted mid-operation: all state cleared on that edge, in-flight responses are forgotten. The memory side must also be reset.

Test Plan:
- Reset release, RESET_PC=0, memory 1-cycle always ready:
  - req addrs 0x0,0x4,0x8… on consecutive cycles.
  - instr_valid first high 2 cycles after first request.
  - instr_pc sequence 0x0,0x4,… at 1/cycle with instr_ready=1.
- Backpressure, instr_ready=0, DEPTH=4:
  - exactly 4 requests issued (0x0–0xC), then imem_req_valid=0.
  - FIFO full, instr held at 0x0.
  - Releasing ready drains in order and resumes fetch at 0x10.
- Redirect with 3 requests in flight (3-cycle memory), redirect_pc=0x103:
  - 3 stale responses discarded.
  - Next request addr 0x100 the cycle after redirect.
  - First instr_pc=0x100.
  - No stale instr_valid.
- Redirect coinciding with a response and with instr_valid&&instr_ready:
  - response dropped, no pop counted.
  - instr_valid low that cycle.
  - Next delivered instr_pc = target.
- imem_req_ready toggling randomly:
  - addresses increment only on acceptance.
  - No duplicate or skipped PCs over 100 instructions.
- XLEN=32, RESET_PC=0xFFFF_FFF8: fetch sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- Mid-stream reset low for 1 cycle:
  - outputs valid=0 that cycle.
  - Fetch restarts at RESET_PC.
  - FIFO empty.
